// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//  Fetch stage. It drives the fetch address to the unified memory, captures the two
//  instructions returned each cycle (addr, addr+4) into a circular queue of {pc, inst},
//  and presents the two oldest entries to decode. Decode pops 0, 1 or 2 entries per
//  cycle. A redirect flushes the queue and restarts fetch at a new word-aligned PC.
// Ports
//  clock, reset          core clock; asynchronous active-low reset
//  io_instAddr           fetch address (always the current PC register)
//  io_mem_inst_0/1       instructions at io_instAddr / io_instAddr+4 (same-cycle read)
//  io_redirect(_pc)      flush and restart fetch at io_redirect_pc with bits [1:0] cleared
//  io_id_valid_0/1       head / head+1 entry valid
//  io_id_inst_0/1        instructions at head / head+1
//  io_id_pc_0/1          PCs at head / head+1
//  io_id_take            entries consumed by decode this cycle (3 behaves as 2)
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [63:0] io_instAddr,
    input  logic [31:0] io_mem_inst_0,
    input  logic [31:0] io_mem_inst_1,
    input  logic        io_redirect,
    input  logic [63:0] io_redirect_pc,
    output logic        io_id_valid_0,
    output logic        io_id_valid_1,
    output logic [31:0] io_id_inst_0,
    output logic [31:0] io_id_inst_1,
    output logic [63:0] io_id_pc_0,
    output logic [63:0] io_id_pc_1,
    input  logic [1:0]  io_id_take
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t            entries_q [DEPTH];
    logic [63:0]       pc_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    logic [CNT_W-1:0]  take_c;
    logic [CNT_W-1:0]  deq_c;
    logic              enq_c;
    logic [CNT_W-1:0]  count_next_c;
    logic [PTR_W-1:0]  head_p1_c;
    logic [PTR_W-1:0]  tail_p1_c;

    // Low address bits of a redirect target are dropped by construction.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^io_redirect_pc[1:0];

    // Dequeue/enqueue decisions; enqueue looks at the pre-dequeue occupancy.
    always_comb begin
        take_c       = (io_id_take == 2'd3) ? CNT_W'(2) : CNT_W'(io_id_take);
        deq_c        = (take_c > count_q) ? count_q : take_c;
        enq_c        = (count_q <= CNT_W'(DEPTH - 2)) && !io_redirect;
        count_next_c = count_q + (enq_c ? CNT_W'(2) : CNT_W'(0)) - deq_c;
        head_p1_c    = head_q + PTR_W'(1);
        tail_p1_c    = tail_q + PTR_W'(1);
    end

    // Control state: redirect wins over normal fetch/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (io_redirect) begin
            pc_q    <= {io_redirect_pc[63:2], 2'b00};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(deq_c);
            count_q <= count_next_c;
            if (enq_c) begin
                tail_q <= tail_q + PTR_W'(2);
                pc_q   <= pc_q + 64'd8;
            end
        end
    end

    // Queue storage is not reset; validity comes from count_q alone.
    always_ff @(posedge clock) begin
        if (enq_c) begin
            entries_q[tail_q]    <= '{pc: pc_q,          inst: io_mem_inst_0};
            entries_q[tail_p1_c] <= '{pc: pc_q + 64'd4,  inst: io_mem_inst_1};
        end
    end

    assign io_instAddr   = pc_q;
    assign io_id_valid_0 = (count_q >= CNT_W'(1));
    assign io_id_valid_1 = (count_q >= CNT_W'(2));
    assign io_id_inst_0  = entries_q[head_q].inst;
    assign io_id_pc_0    = entries_q[head_q].pc;
    assign io_id_inst_1  = entries_q[head_p1_c].inst;
    assign io_id_pc_1    = entries_q[head_p1_c].pc;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue
//  Drives the fetch queue with directed and random take/redirect traffic against a
//  memory whose contents are a function of address, and compares every cycle with a
//  queue-based reference model. Literal expectations pin the model at key points.
module tb_if_fetch_queue;

    localparam int unsigned DEPTH = 8;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] io_instAddr;
    logic [31:0] io_mem_inst_0, io_mem_inst_1;
    logic        io_redirect;
    logic [63:0] io_redirect_pc;
    logic        io_id_valid_0, io_id_valid_1;
    logic [31:0] io_id_inst_0, io_id_inst_1;
    logic [63:0] io_id_pc_0, io_id_pc_1;
    logic [1:0]  io_id_take;

    int checks = 0;
    int errors = 0;
    int mode   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .io_instAddr(io_instAddr),
        .io_mem_inst_0(io_mem_inst_0), .io_mem_inst_1(io_mem_inst_1),
        .io_redirect(io_redirect), .io_redirect_pc(io_redirect_pc),
        .io_id_valid_0(io_id_valid_0), .io_id_valid_1(io_id_valid_1),
        .io_id_inst_0(io_id_inst_0), .io_id_inst_1(io_id_inst_1),
        .io_id_pc_0(io_id_pc_0), .io_id_pc_1(io_id_pc_1),
        .io_id_take(io_id_take)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_fn(input logic [63:0] a, input int md);
        case (md)
            0:       return 32'h0000_0013;
            1:       return a[31:0];
            default: return {a[15:0], ~a[15:0]} ^ a[47:16];
        endcase
    endfunction

    assign io_mem_inst_0 = mem_fn(io_instAddr, mode);
    assign io_mem_inst_1 = mem_fn(io_instAddr + 64'd4, mode);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-queue semantics from the fetch/pop/redirect rules.
    task automatic model_step(input logic [1:0] t, input logic r, input logic [63:0] rpc);
        int take, deq;
        if (r) begin
            mq.delete();
            m_pc = {rpc[63:2], 2'b00};
            return;
        end
        take = (t == 2'd3) ? 2 : int'(t);
        deq  = (take > mq.size()) ? mq.size() : take;
        if (mq.size() <= DEPTH - 2) begin
            mq.push_back('{pc: m_pc,          inst: mem_fn(m_pc, mode)});
            mq.push_back('{pc: m_pc + 64'd4,  inst: mem_fn(m_pc + 64'd4, mode)});
            m_pc = m_pc + 64'd8;
        end
        for (int i = 0; i < deq; i++) void'(mq.pop_front());
    endtask

    // Per-cycle output comparison against the model.
    task automatic compare_all();
        chk("instAddr", io_instAddr, m_pc);
        chk("valid_0", 64'(io_id_valid_0), 64'(mq.size() >= 1));
        chk("valid_1", 64'(io_id_valid_1), 64'(mq.size() >= 2));
        if (mq.size() >= 1 && io_id_valid_0) begin
            chk("pc_0", io_id_pc_0, mq[0].pc);
            chk("inst_0", 64'(io_id_inst_0), 64'(mq[0].inst));
        end
        if (mq.size() >= 2 && io_id_valid_1) begin
            chk("pc_1", io_id_pc_1, mq[1].pc);
            chk("inst_1", 64'(io_id_inst_1), 64'(mq[1].inst));
        end
    endtask

    task automatic step(input logic [1:0] t, input logic r, input logic [63:0] rpc);
        io_id_take     = t;
        io_redirect    = r;
        io_redirect_pc = rpc;
        @(posedge clock);
        model_step(t, r, rpc);
        #1;
        compare_all();
    endtask

    function automatic logic [1:0] legal_take(input int want);
        int n;
        n = mq.size();
        if (want == 3) return (n >= 2) ? 2'd3 : 2'(n);
        return (want > n) ? 2'(n) : 2'(want);
    endfunction

    initial begin
        reset = 1'b0; io_id_take = 2'd0; io_redirect = 1'b0; io_redirect_pc = 64'h0;
        m_pc = RESET_PC;
        #2;
        chk("rst_valid_0", 64'(io_id_valid_0), 64'd0);
        chk("rst_instAddr", io_instAddr, RESET_PC);
        #10 reset = 1'b1;

        // Fill from reset with take=0.
        step(2'd0, 1'b0, 64'h0);
        chk("c1_valid_1", 64'(io_id_valid_1), 64'd1);
        chk("c1_pc_0", io_id_pc_0, 64'h0);
        chk("c1_pc_1", io_id_pc_1, 64'h4);
        chk("c1_inst_0", 64'(io_id_inst_0), 64'h13);
        for (int i = 0; i < 3; i++) step(2'd0, 1'b0, 64'h0);
        chk("fill_model_count", 64'(mq.size()), 64'd8);
        chk("fill_instAddr", io_instAddr, 64'h20);
        step(2'd0, 1'b0, 64'h0);
        chk("full_hold_instAddr", io_instAddr, 64'h20);

        // Full, pop one: no enqueue, then one free slot still blocks fetch.
        step(2'd1, 1'b0, 64'h0);
        chk("pop1_count", 64'(mq.size()), 64'd7);
        chk("pop1_instAddr", io_instAddr, 64'h20);
        step(2'd0, 1'b0, 64'h0);
        chk("hold7_count", 64'(mq.size()), 64'd7);
        chk("hold7_instAddr", io_instAddr, 64'h20);

        // Redirect at count=5 with take=2.
        step(2'd2, 1'b0, 64'h0);
        chk("pre_redir_count", 64'(mq.size()), 64'd5);
        step(2'd2, 1'b1, 64'h103);
        chk("redir_valid_0", 64'(io_id_valid_0), 64'd0);
        chk("redir_instAddr", io_instAddr, 64'h100);
        step(2'd0, 1'b0, 64'h0);
        chk("redir_pc_0", io_id_pc_0, 64'h100);
        chk("redir_pc_1", io_id_pc_1, 64'h104);

        // Sustained take=2.
        for (int k = 1; k <= 10; k++) begin
            step(2'd2, 1'b0, 64'h0);
            chk("stream_pc_0", io_id_pc_0, 64'h100 + 64'(8 * k));
            chk("stream_valid_1", 64'(io_id_valid_1), 64'd1);
            chk("stream_instAddr", io_instAddr, 64'h108 + 64'(8 * k));
        end

        // Tail wrap with inst == addr memory, alternating take 1/2.
        mode = 1;
        step(2'd0, 1'b1, 64'h1000);
        for (int k = 0; k < 20; k++) begin
            step(legal_take((k % 2 == 0) ? 1 : 2), 1'b0, 64'h0);
            if (io_id_valid_0) chk("wrap_inst_eq_pc", 64'(io_id_inst_0), 64'(io_id_pc_0[31:0]));
            if (io_id_valid_1) chk("wrap_seq", io_id_pc_1, io_id_pc_0 + 64'd4);
        end

        // Random traffic, including redirects near the 64-bit wrap.
        mode = 2;
        step(2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF3);
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 19) == 0)
                step(2'($urandom_range(0, 3)), 1'b1, {$urandom(), $urandom()});
            else
                step(legal_take(int'($urandom_range(0, 3))), 1'b0, 64'h0);
        end

        // Asynchronous reset mid-stream at count=6.
        step(2'd0, 1'b1, 64'h4000);
        for (int i = 0; i < 3; i++) step(2'd0, 1'b0, 64'h0);
        chk("pre_reset_count", 64'(mq.size()), 64'd6);
        #2 reset = 1'b0;
        #1;
        mq.delete();
        m_pc = RESET_PC;
        chk("async_valid_0", 64'(io_id_valid_0), 64'd0);
        chk("async_valid_1", 64'(io_id_valid_1), 64'd0);
        chk("async_instAddr", io_instAddr, RESET_PC);
        #3 reset = 1'b1;
        step(2'd0, 1'b0, 64'h0);
        chk("restart_pc_0", io_id_pc_0, 64'h0);
        chk("restart_pc_1", io_id_pc_1, 64'h4);
        chk("restart_instAddr", io_instAddr, 64'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
